// File: rtl/led_shift_sequencer.sv
// Step-tick prescaler plus mode FSM that animates an LED pattern register.
// Switch inputs are resynchronized; mode and pattern only advance on a tick.
module led_shift_sequencer #(
  parameter int DIV   = 50_000_000,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode_sw,
  input  logic             pause_sw,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic [1:0]       cur_mode,
  output logic             dir
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {
    JOHN_L = 2'b00,
    JOHN_R = 2'b01,
    BOUNCE = 2'b10,
    HOLD   = 2'b11
  } mode_e;

  logic [CW-1:0]    div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;
  logic [1:0]       mode_s1_q, mode_s_q;
  logic             pause_s1_q, pause_s_q;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             dir_q, dir_d;

  // Prescaler runs independently of mode and pause.
  always_comb begin
    div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + CW'(1);
    tick_d    = (div_cnt_q == LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      tick_q     <= 1'b0;
      mode_s1_q  <= 2'b00;
      mode_s_q   <= 2'b00;
      pause_s1_q <= 1'b0;
      pause_s_q  <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      tick_q     <= tick_d;
      mode_s1_q  <= mode_sw;
      mode_s_q   <= mode_s1_q;
      pause_s1_q <= pause_sw;
      pause_s_q  <= pause_s1_q;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= JOHN_L;
      led_q  <= '0;
      dir_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      led_q  <= led_d;
      dir_q  <= dir_d;
    end
  end

  // Next state: the freshly synchronized mode is both latched and applied on a tick.
  always_comb begin
    mode_d = mode_q;
    led_d  = led_q;
    dir_d  = dir_q;
    if (tick_q) begin
      mode_d = mode_e'(mode_s_q);
      if (!pause_s_q) begin
        case (mode_e'(mode_s_q))
          JOHN_L: led_d = {led_q[WIDTH-2:0], ~led_q[WIDTH-1]};
          JOHN_R: led_d = {~led_q[0], led_q[WIDTH-1:1]};
          BOUNCE: begin
            if (!$onehot(led_q)) begin
              led_d = WIDTH'(1);
              dir_d = 1'b0;
            end else if (!dir_q && led_q[WIDTH-1]) begin
              led_d = led_q >> 1;
              dir_d = 1'b1;
            end else if (dir_q && led_q[0]) begin
              led_d = led_q << 1;
              dir_d = 1'b0;
            end else if (dir_q) begin
              led_d = led_q >> 1;
            end else begin
              led_d = led_q << 1;
            end
          end
          HOLD: led_d = led_q;
          default: led_d = led_q;
        endcase
      end
    end
  end

  // Outputs are the registered state directly.
  always_comb begin
    led      = led_q;
    tick     = tick_q;
    cur_mode = mode_q;
    dir      = dir_q;
  end

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Bench for led_shift_sequencer: directed tick-by-tick table, hand-written corner
// sequences, then random switching compared every cycle against a reference model.
module tb_led_shift_sequencer;

  localparam int DIV = 4;
  localparam int W   = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   mode_sw = 2'b00;
  logic         pause_sw = 1'b0;
  logic [W-1:0] led;
  logic         tick;
  logic [1:0]   cur_mode;
  logic         dir;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_shift_sequencer #(.DIV(DIV), .WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode_sw  (mode_sw),
    .pause_sw (pause_sw),
    .led      (led),
    .tick     (tick),
    .cur_mode (cur_mode),
    .dir      (dir)
  );

  // Reference model state
  logic [7:0] m_led;
  logic       m_dir;
  logic [1:0] m_mode;
  logic       m_tick;
  int         m_edges;
  logic [1:0] mh[$];
  logic       ph[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic apply_mode(input logic [1:0] md);
    int v;
    int p;
    v = int'(m_led);
    case (md)
      2'd0: m_led = 8'((v * 2) % 256 + ((v < 128) ? 1 : 0));
      2'd1: m_led = 8'(v / 2 + (((v % 2) == 0) ? 128 : 0));
      2'd2: begin
        if ($countones(m_led) != 1) begin
          m_led = 8'd1;
          m_dir = 1'b0;
        end else begin
          p = $clog2(v);
          if (!m_dir) begin
            if (p == W - 1) begin m_dir = 1'b1; p = p - 1; end
            else p = p + 1;
          end else begin
            if (p == 0) begin m_dir = 1'b0; p = 1; end
            else p = p - 1;
          end
          m_led = 8'(1 << p);
        end
      end
      default: ;
    endcase
  endtask

  // Switch samples two edges old are what the design acts on.
  task automatic model_step();
    if (rst) begin
      m_led = 8'h00; m_dir = 1'b0; m_mode = 2'b00; m_tick = 1'b0; m_edges = 0;
      mh.delete(); ph.delete();
      mh.push_back(2'b00); mh.push_back(2'b00);
      ph.push_back(1'b0);  ph.push_back(1'b0);
    end else begin
      if (m_tick) begin
        m_mode = mh[mh.size() - 2];
        if (!ph[ph.size() - 2]) apply_mode(m_mode);
      end
      m_edges++;
      m_tick = ((m_edges % DIV) == 0);
      mh.push_back(mode_sw);
      ph.push_back(pause_sw);
      if (mh.size() > 4) void'(mh.pop_front());
      if (ph.size() > 4) void'(ph.pop_front());
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  // Advance until the design has applied the next tick.
  task automatic wait_update();
    int k;
    k = 0;
    while (!tick && k < 3 * DIV) begin
      cyc();
      k++;
    end
    check("tick_seen", {31'd0, tick}, 32'd1);
    cyc();
  endtask

  typedef struct {
    bit         rst_first;
    logic [1:0] mode;
    logic       pause;
    logic [7:0] exp_led;
    logic [1:0] exp_mode;
    logic       exp_dir;
  } vec_t;

  vec_t vt[$];

  task automatic add(input bit r, input logic [1:0] md, input logic ps,
                     input logic [7:0] l, input logic [1:0] cm, input logic d);
    vec_t v;
    v.rst_first = r; v.mode = md; v.pause = ps;
    v.exp_led = l; v.exp_mode = cm; v.exp_dir = d;
    vt.push_back(v);
  endtask

  initial begin
    logic [7:0] jl[17];
    logic [7:0] jr[17];
    logic [7:0] bn[16];
    logic       bd[16];
    int k;

    jl = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
           8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
    jr = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'h7F,
           8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h80};
    bn = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
           8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    bd = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};

    for (int i = 0; i < 17; i++) add(i == 0, 2'd0, 1'b0, jl[i], 2'd0, 1'b0);
    for (int i = 0; i < 17; i++) add(i == 0, 2'd1, 1'b0, jr[i], 2'd1, 1'b0);
    for (int i = 0; i < 4; i++)  add(i == 0, 2'd0, 1'b0, jl[i], 2'd0, 1'b0);
    for (int i = 0; i < 16; i++) add(1'b0, 2'd2, 1'b0, bn[i], 2'd2, bd[i]);
    for (int i = 0; i < 3; i++)  add(i == 0, 2'd0, 1'b0, jl[i], 2'd0, 1'b0);
    for (int i = 0; i < 5; i++)  add(1'b0, 2'd0, 1'b1, 8'h07, 2'd0, 1'b0);
    add(1'b0, 2'd0, 1'b0, 8'h0F, 2'd0, 1'b0);
    add(1'b0, 2'd0, 1'b0, 8'h1F, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++)  add(1'b0, 2'd3, 1'b0, 8'h1F, 2'd3, 1'b0);
    add(1'b0, 2'd0, 1'b0, 8'h3F, 2'd0, 1'b0);

    // Reset state
    cyc();
    do_reset();
    check("rst_led", {24'd0, led}, 32'h00);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_mode", {30'd0, cur_mode}, 32'd0);
    check("rst_dir", {31'd0, dir}, 32'd0);

    // Directed table
    foreach (vt[i]) begin
      mode_sw  = vt[i].mode;
      pause_sw = vt[i].pause;
      if (vt[i].rst_first) do_reset();
      wait_update();
      check($sformatf("vec%0d_led", i), {24'd0, led}, {24'd0, vt[i].exp_led});
      check($sformatf("vec%0d_mode", i), {30'd0, cur_mode}, {30'd0, vt[i].exp_mode});
      check($sformatf("vec%0d_dir", i), {31'd0, dir}, {31'd0, vt[i].exp_dir});
    end

    // Mode change mid-interval waits for the next tick
    mode_sw = 2'd0; pause_sw = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) wait_update();
    check("mid_led_start", {24'd0, led}, 32'h07);
    mode_sw = 2'd1;
    cyc();
    cyc();
    check("mid_mode_held", {30'd0, cur_mode}, 32'd0);
    check("mid_led_held", {24'd0, led}, 32'h07);
    wait_update();
    check("mid_mode_new", {30'd0, cur_mode}, 32'd1);
    check("mid_led_1", {24'd0, led}, 32'h03);
    wait_update();
    check("mid_led_2", {24'd0, led}, 32'h01);
    wait_update();
    check("mid_led_3", {24'd0, led}, 32'h00);
    wait_update();
    check("mid_led_4", {24'd0, led}, 32'h80);

    // Reset in the middle of a bounce walk heading toward the LSB
    mode_sw = 2'd2;
    do_reset();
    for (int i = 0; i < 9; i++) wait_update();
    check("bw_led", {24'd0, led}, 32'h40);
    check("bw_dir", {31'd0, dir}, 32'd1);
    check("bw_mode", {30'd0, cur_mode}, 32'd2);
    cyc();
    rst = 1'b1;
    mode_sw = 2'd0;
    cyc();
    rst = 1'b0;
    check("bwr_led", {24'd0, led}, 32'h00);
    check("bwr_mode", {30'd0, cur_mode}, 32'd0);
    check("bwr_dir", {31'd0, dir}, 32'd0);
    check("bwr_tick", {31'd0, tick}, 32'd0);
    k = 0;
    while (!tick && k < 3 * DIV) begin
      cyc();
      k++;
    end
    check("first_tick_latency", k, DIV);
    cyc();
    check("bwr_resume", {24'd0, led}, 32'h01);

    // Random switching against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) == 0) mode_sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) pause_sw = ~pause_sw;
      rst = ($urandom_range(0, 149) == 0);
      cyc();
      check("rnd_led", {24'd0, led}, {24'd0, m_led});
      check("rnd_tick", {31'd0, tick}, {31'd0, m_tick});
      check("rnd_mode", {30'd0, cur_mode}, {30'd0, m_mode});
      check("rnd_dir", {31'd0, dir}, {31'd0, m_dir});
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
